cavlc_runbefore_ctrl: RTL and testbench

Per-block sequencer for the CAVLC run_before encoder engine. Accepts one zig-zag-ordered 4x4 coefficient block through a valid/ready handshake and derives TotalCoeff, TotalZeros and the rightmost nonzero index. It launches the run_before engine with a one-cycle enable, waits for its finish, and presents the captured run_before bitstring downstream through a second valid/ready handshake. It sits between the zig-zag scan stage and the CAVLC bitstream packer.

---
 rtl/cavlc_pkg.sv | 17 +
 rtl/cavlc_blk_stats.sv | 25 ++
 rtl/cavlc_runbefore_ctrl.sv | 122 ++++++++++++
 tb/tb_cavlc_runbefore_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// Shared types and widths for the CAVLC run_before control path.
package cavlc_pkg;
  localparam int COEF_W = 15;
  localparam int NCOEF  = 16;
  localparam int TC_W   = 5;
  localparam int IDX_W  = 4;
  localparam int LEN_W  = 5;
  localparam int BITS_W = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_WAIT,
    S_OUT
  } state_t;
endpackage

// File: rtl/cavlc_blk_stats.sv
// Block statistics: nonzero count, rightmost nonzero index and TotalZeros.
module cavlc_blk_stats
  import cavlc_pkg::*;
(
  input  logic signed [COEF_W-1:0] coef [NCOEF],
  output logic        [TC_W-1:0]   totalcoeff,
  output logic        [IDX_W-1:0]  rightmost,
  output logic        [IDX_W-1:0]  totalzero
);
  logic [TC_W-1:0] tz_full;

  always_comb begin
    totalcoeff = '0;
    rightmost  = '0;
    for (int i = 0; i < NCOEF; i++) begin
      if (coef[i] != '0) begin
        totalcoeff = totalcoeff + TC_W'(1);
        rightmost  = IDX_W'(i);
      end
    end
    // An all-zero block wraps to 1 here; the controller skips it on TotalCoeff==0.
    tz_full   = TC_W'(rightmost) + TC_W'(1) - totalcoeff;
    totalzero = tz_full[IDX_W-1:0];
  end
endmodule

// File: rtl/cavlc_runbefore_ctrl.sv
// Per-block sequencer: accept block, compute stats, launch run_before engine, hand result downstream.
module cavlc_runbefore_ctrl
  import cavlc_pkg::*;
#(
  parameter int WD_LIMIT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic signed [COEF_W-1:0] blk_coef [NCOEF],
  output logic                     rb_enable,
  output logic        [IDX_W-1:0]  rb_rightmost_idx,
  output logic        [TC_W-1:0]   rb_totalcoeff,
  output logic        [IDX_W-1:0]  rb_totalzero,
  output logic signed [COEF_W-1:0] rb_coef [NCOEF],
  input  logic                     rb_finish,
  input  logic        [LEN_W-1:0]  rb_code_length,
  input  logic        [BITS_W-1:0] rb_code_bit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [TC_W-1:0]   out_totalcoeff,
  output logic        [IDX_W-1:0]  out_totalzero,
  output logic        [LEN_W-1:0]  out_code_length,
  output logic        [BITS_W-1:0] out_code_bit,
  output logic                     out_err
);
  localparam int WD_W = $clog2(WD_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  state_t            state, state_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic [TC_W-1:0]   st_tc;
  logic [IDX_W-1:0]  st_rm;
  logic [IDX_W-1:0]  st_tz;
  logic              skip;

  cavlc_blk_stats u_stats (
    .coef       (rb_coef),
    .totalcoeff (st_tc),
    .rightmost  (st_rm),
    .totalzero  (st_tz)
  );

  assign skip = (st_tc == '0) || (st_tz == '0);

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    rb_enable = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) state_nxt = S_SCAN;
      end
      S_SCAN:   state_nxt = skip ? S_OUT : S_LAUNCH;
      S_LAUNCH: begin
        rb_enable = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:   if (rb_finish || (wd_cnt == WD_LAST)) state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      wd_cnt           <= '0;
      rb_rightmost_idx <= '0;
      rb_totalcoeff    <= '0;
      rb_totalzero     <= '0;
      for (int i = 0; i < NCOEF; i++) rb_coef[i] <= '0;
      out_totalcoeff   <= '0;
      out_totalzero    <= '0;
      out_code_length  <= '0;
      out_code_bit     <= '0;
      out_err          <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (blk_valid) rb_coef <= blk_coef;
        S_SCAN: begin
          rb_totalcoeff    <= st_tc;
          rb_rightmost_idx <= st_rm;
          rb_totalzero     <= st_tz;
          if (skip) begin
            out_totalcoeff  <= st_tc;
            out_totalzero   <= st_tz;
            out_code_length <= '0;
            out_code_bit    <= '0;
            out_err         <= 1'b0;
          end
        end
        S_LAUNCH: wd_cnt <= '0;
        S_WAIT: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          // The engine clears its outputs on the next edge, so capture on the finish cycle itself.
          if (rb_finish) begin
            out_totalcoeff  <= rb_totalcoeff;
            out_totalzero   <= rb_totalzero;
            out_code_length <= rb_code_length;
            out_code_bit    <= rb_code_bit;
            out_err         <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            out_totalcoeff  <= rb_totalcoeff;
            out_totalzero   <= rb_totalzero;
            out_code_length <= '0;
            out_code_bit    <= '0;
            out_err         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cavlc_runbefore_ctrl.sv
// Scoreboard bench for cavlc_runbefore_ctrl with a behavioural run_before engine model.
module tb_cavlc_runbefore_ctrl;
  import cavlc_pkg::*;
  localparam int WD_LIMIT = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic blk_valid = 1'b0;
  logic blk_ready;
  logic signed [COEF_W-1:0] blk_coef [NCOEF];
  logic rb_enable;
  logic [IDX_W-1:0] rb_rightmost_idx;
  logic [TC_W-1:0] rb_totalcoeff;
  logic [IDX_W-1:0] rb_totalzero;
  logic signed [COEF_W-1:0] rb_coef [NCOEF];
  logic rb_finish = 1'b0;
  logic [LEN_W-1:0] rb_code_length = '0;
  logic [BITS_W-1:0] rb_code_bit = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [TC_W-1:0] out_totalcoeff;
  logic [IDX_W-1:0] out_totalzero;
  logic [LEN_W-1:0] out_code_length;
  logic [BITS_W-1:0] out_code_bit;
  logic out_err;

  cavlc_runbefore_ctrl #(.WD_LIMIT(WD_LIMIT)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_coef(blk_coef),
    .rb_enable(rb_enable), .rb_rightmost_idx(rb_rightmost_idx), .rb_totalcoeff(rb_totalcoeff),
    .rb_totalzero(rb_totalzero), .rb_coef(rb_coef), .rb_finish(rb_finish),
    .rb_code_length(rb_code_length), .rb_code_bit(rb_code_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_totalcoeff(out_totalcoeff), .out_totalzero(out_totalzero),
    .out_code_length(out_code_length), .out_code_bit(out_code_bit), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TC_W-1:0]   tc;
    logic [IDX_W-1:0]  tz;
    logic [LEN_W-1:0]  len;
    logic [BITS_W-1:0] bits;
    logic              err;
    int                at;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Output monitor: compare each new result against the oldest expectation.
  logic ov_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !ov_q) begin
      if (sb.size() == 0) chk("unexpected_out", out_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("out_tc", out_totalcoeff, e.tc);
        chk("out_tz", out_totalzero, e.tz);
        chk("out_len", out_code_length, e.len);
        chk("out_bits", out_code_bit, e.bits);
        chk("out_err", out_err, e.err);
        chk("out_latency", cyc, e.at);
      end
    end
    ov_q <= out_valid;
  end

  // Engine model: finish pulse eng_delay cycles into WAIT (negative delay = never).
  int eng_delay = -1;
  int eng_cnt = -1;
  logic [LEN_W-1:0] eng_len = '0;
  logic [BITS_W-1:0] eng_bits = '0;
  int n_en = 0;
  logic [TC_W-1:0] cap_tc;
  logic [IDX_W-1:0] cap_rm, cap_tz;
  logic signed [COEF_W-1:0] cap_coef [NCOEF];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rb_finish = 1'b0;
      rb_code_length = '0;
      rb_code_bit = '0;
      if (eng_cnt == 0) begin
        rb_finish = 1'b1;
        rb_code_length = eng_len;
        rb_code_bit = eng_bits;
        eng_cnt = -1;
      end else if (eng_cnt > 0) eng_cnt--;
      if (rb_enable) begin
        n_en++;
        eng_cnt = eng_delay;
        cap_tc = rb_totalcoeff;
        cap_rm = rb_rightmost_idx;
        cap_tz = rb_totalzero;
        cap_coef = rb_coef;
      end
    end
  end

  logic signed [COEF_W-1:0] stim [NCOEF];

  task automatic clear_stim();
    for (int i = 0; i < NCOEF; i++) stim[i] = '0;
  endtask

  task automatic calc(output logic [TC_W-1:0] tc, output logic [IDX_W-1:0] tz, output int rm);
    int z;
    tc = '0;
    rm = -1;
    z = 0;
    for (int i = 0; i < NCOEF; i++) if (stim[i] != 0) tc = tc + TC_W'(1);
    for (int i = NCOEF - 1; i >= 0; i--) if (rm < 0 && stim[i] != 0) rm = i;
    if (rm < 0) tz = 4'd1;
    else begin
      for (int i = 0; i < rm; i++) if (stim[i] == 0) z++;
      tz = z[IDX_W-1:0];
    end
  endtask

  task automatic run_block(input int d, input logic [LEN_W-1:0] len, input logic [BITS_W-1:0] bits,
                           input int hold);
    logic [TC_W-1:0] tc;
    logic [IDX_W-1:0] tz;
    int rm, n0, w, nacc;
    bit skip;
    calc(tc, tz, rm);
    skip = (tc == 0) || (tz == 0);
    cur.tc = tc;
    cur.tz = tz;
    cur.err = !skip && (d < 0 || d > WD_LIMIT - 1);
    cur.len = (skip || cur.err) ? '0 : len;
    cur.bits = (skip || cur.err) ? '0 : bits;
    eng_delay = d;
    eng_len = len;
    eng_bits = bits;
    n0 = n_en;
    w = 0;
    while (!blk_ready && w < 100) begin @(posedge clk); #1; w++; end
    chk("blk_ready_wait", blk_ready, 1'b1);
    blk_valid = 1'b1;
    blk_coef = stim;
    @(posedge clk);
    #1;
    nacc = cyc;
    blk_valid = 1'b0;
    cur.at = skip ? nacc + 1 : (cur.err ? nacc + 2 + WD_LIMIT : nacc + 3 + d);
    sb.push_back(cur);
    w = 0;
    while (!out_valid && w < WD_LIMIT + 40) begin @(posedge clk); #1; w++; end
    chk("out_valid_wait", out_valid, 1'b1);
    for (int k = 0; k < hold; k++) begin
      chk("stall_tc", out_totalcoeff, cur.tc);
      chk("stall_len", out_code_length, cur.len);
      chk("stall_bits", out_code_bit, cur.bits);
      chk("stall_err", out_err, cur.err);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_blk_ready", blk_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_drop", out_valid, 1'b0);
    chk("idle_blk_ready", blk_ready, 1'b1);
    chk("n_enable", n_en - n0, skip ? 0 : 1);
    if (!skip) begin
      chk("rb_tc", cap_tc, tc);
      chk("rb_rm", cap_rm, rm);
      chk("rb_tz", cap_tz, tz);
      for (int i = 0; i < NCOEF; i++) chk("rb_coef", cap_coef[i], stim[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d want completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rv;
    int nacc;
    for (int i = 0; i < NCOEF; i++) blk_coef[i] = '0;
    clear_stim();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_blk_ready", blk_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rb_enable", rb_enable, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_out_len", out_code_length, '0);
    chk("rst_rb_tc", rb_totalcoeff, '0);
    rst = 1'b0;

    // Sparse block, engine returns 3 bits 010.
    clear_stim();
    stim[0] = 15'sd3; stim[2] = -15'sd1; stim[5] = 15'sd2;
    run_block(2, 5'd3, 25'b010, 0);

    // All nonzero: TotalZeros=0, skip.
    for (int i = 0; i < NCOEF; i++) stim[i] = 15'(i + 1);
    run_block(2, 5'd7, 25'h55, 0);

    // All zero: TotalCoeff=0, skip.
    clear_stim();
    run_block(2, 5'd7, 25'h55, 0);

    // Engine never finishes: watchdog abort, then normal block.
    clear_stim();
    stim[1] = 15'sd9; stim[7] = -15'sd4;
    run_block(-1, 5'd4, 25'hF, 0);
    clear_stim();
    stim[0] = 15'sd3; stim[2] = -15'sd1; stim[5] = 15'sd2;
    run_block(0, 5'd3, 25'b010, 0);

    // Finish on the watchdog's last cycle wins.
    clear_stim();
    stim[3] = 15'sd1;
    run_block(WD_LIMIT - 1, 5'd2, 25'b11, 0);

    // Downstream stall for 10 cycles.
    clear_stim();
    stim[4] = 15'sd5; stim[10] = 15'sd6;
    run_block(3, 5'd9, 25'h1A5, 10);

    // Extreme coefficient at the last index, maximum TotalZeros and full-width code.
    clear_stim();
    stim[15] = -15'sd16384;
    run_block(1, 5'd25, 25'h1FFFFFF, 0);

    // Random blocks.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NCOEF; i++) begin
        rv = $urandom;
        stim[i] = ($urandom_range(0, 2) == 0) ? rv[COEF_W-1:0] : '0;
      end
      rv = $urandom;
      run_block($urandom_range(0, 5), rv[LEN_W-1:0], rv[BITS_W+6:7], r % 3);
    end

    // Reset in the middle of WAIT; the late finish must be ignored.
    clear_stim();
    stim[0] = 15'sd3; stim[2] = -15'sd1; stim[5] = 15'sd2;
    eng_delay = 8;
    eng_len = 5'd3;
    eng_bits = 25'b010;
    blk_valid = 1'b1;
    blk_coef = stim;
    @(posedge clk);
    #1;
    nacc = cyc;
    blk_valid = 1'b0;
    while (cyc < nacc + 4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("wrst_out_valid", out_valid, 1'b0);
    chk("wrst_blk_ready", blk_ready, 1'b1);
    chk("wrst_rb_enable", rb_enable, 1'b0);
    chk("wrst_rb_tc", rb_totalcoeff, '0);
    chk("wrst_rb_coef5", rb_coef[5], '0);
    chk("wrst_out_err", out_err, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_out_valid", out_valid, 1'b0);
      chk("post_rst_blk_ready", blk_ready, 1'b1);
    end

    // Normal operation after the mid-WAIT reset.
    clear_stim();
    stim[2] = 15'sd8; stim[6] = 15'sd1; stim[9] = -15'sd2;
    run_block(1, 5'd6, 25'h2D, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
